branch_predictor: RTL

Fetch-stage branch predictor: a direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
- **Lookup:** each cycle the fetch PC is looked up combinationally to produce a predicted direction and next PC.
- **Update:** the execute stage writes resolved branch outcomes back, using the branch condition from the branch unit and the computed target.
- **Redirect:** on a wrong prediction the block issues a registered one-cycle redirect that the fetch stage uses to flush and restart.

---
 rtl/branch_predictor_if.sv | 59 +++++
 rtl/branch_predictor.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/execute <-> branch predictor bundle: lookup, resolved-branch update, redirect and stats.
// Latency: lookup is combinational; redirect and counters are registered (one cycle after update).
// Backpressure: none; the predictor accepts a lookup and an update every cycle.
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    // fetch-side lookup
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    // execute-side resolved branch
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_pred_taken;
    logic [XLEN-1:0] upd_pred_target;

    // refetch request and statistics
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [15:0]     branch_count;
    logic [15:0]     mispredict_count;

    // predictor side
    modport slave (
        input  if_pc,
        output pred_taken,
        output pred_target,
        input  upd_valid,
        input  upd_pc,
        input  upd_taken,
        input  upd_target,
        input  upd_pred_taken,
        input  upd_pred_target,
        output redirect_valid,
        output redirect_pc,
        output branch_count,
        output mispredict_count
    );

    // pipeline side (fetch + execute)
    modport master (
        output if_pc,
        input  pred_taken,
        input  pred_target,
        output upd_valid,
        output upd_pc,
        output upd_taken,
        output upd_target,
        output upd_pred_taken,
        output upd_pred_target,
        input  redirect_valid,
        input  redirect_pc,
        input  branch_count,
        input  mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters; issues a refetch on mispredict.
// Latency: lookup 0 cycles (combinational); table write, redirect and counters land on the next edge.
// Backpressure: none; one lookup and one update are accepted every cycle, no stall path.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    branch_predictor_if.slave   bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - 2 - IDX_W;

    // Table depth must be a power of two so the index is a plain PC bit slice.
    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("branch_predictor: ENTRIES must be a power of two and at least 2");
    end

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [1:0]       ctr;
    } entry_t;

    // Counters come out of reset weakly not-taken so a fresh allocation (2'b10) is distinct.
    localparam entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};

    entry_t tbl_q [ENTRIES];

    // PC bits [1:0] never participate in indexing or tagging.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bus.if_pc[1:0], bus.upd_pc[1:0]};

    // ---------------------------------------------------------------
    // Lookup path
    // ---------------------------------------------------------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    entry_t           lk_ent;
    logic             lk_hit;
    logic             lk_taken;

    assign lk_idx = bus.if_pc[IDX_W+1:2];
    assign lk_tag = bus.if_pc[XLEN-1:IDX_W+2];

    // Read the stored entry directly; an update in the same cycle is not bypassed.
    always_comb begin
        lk_ent   = tbl_q[lk_idx];
        lk_hit   = lk_ent.valid && (lk_ent.tag == lk_tag);
        lk_taken = lk_hit && lk_ent.ctr[1];
    end

    assign bus.pred_taken  = lk_taken;
    assign bus.pred_target = lk_taken ? lk_ent.target : (bus.if_pc + XLEN'(4));

    // ---------------------------------------------------------------
    // Update path
    // ---------------------------------------------------------------
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    entry_t           upd_old;
    logic             upd_hit;
    entry_t           upd_ent_d;
    logic             upd_we;

    assign upd_idx = bus.upd_pc[IDX_W+1:2];
    assign upd_tag = bus.upd_pc[XLEN-1:IDX_W+2];

    // Next contents of the indexed entry: train on a hit, allocate only on a taken miss.
    always_comb begin
        upd_old   = tbl_q[upd_idx];
        upd_hit   = upd_old.valid && (upd_old.tag == upd_tag);
        upd_ent_d = upd_old;
        upd_we    = 1'b0;
        if (bus.upd_valid) begin
            if (upd_hit) begin
                upd_we = 1'b1;
                if (bus.upd_taken) begin
                    upd_ent_d.target = bus.upd_target;
                    if (upd_old.ctr != 2'b11) begin
                        upd_ent_d.ctr = upd_old.ctr + 2'd1;
                    end
                end else if (upd_old.ctr != 2'b00) begin
                    upd_ent_d.ctr = upd_old.ctr - 2'd1;
                end
            end else if (bus.upd_taken) begin
                upd_we           = 1'b1;
                upd_ent_d.valid  = 1'b1;
                upd_ent_d.tag    = upd_tag;
                upd_ent_d.target = bus.upd_target;
                upd_ent_d.ctr    = 2'b10;
            end
        end
    end

    // Table storage: whole table cleared on reset, single-entry write otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= RESET_ENTRY;
            end
        end else if (upd_we) begin
            tbl_q[upd_idx] <= upd_ent_d;
        end
    end

    // ---------------------------------------------------------------
    // Mispredict detection, redirect and statistics
    // ---------------------------------------------------------------
    logic            mispredict;
    logic [XLEN-1:0] correct_pc;

    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [15:0]     branch_count_q, branch_count_d;
    logic [15:0]     mispredict_count_q, mispredict_count_d;

    // A taken branch is also wrong if fetch went to a stale target.
    always_comb begin
        mispredict = bus.upd_valid &&
                     ((bus.upd_taken != bus.upd_pred_taken) ||
                      (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));
        correct_pc = bus.upd_taken ? bus.upd_target : (bus.upd_pc + XLEN'(4));
    end

    // Redirect pulses for one cycle per mispredict; the PC is held between pulses.
    always_comb begin
        redirect_valid_d   = mispredict;
        redirect_pc_d      = mispredict ? correct_pc : redirect_pc_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (bus.upd_valid && (branch_count_q != 16'hFFFF)) begin
            branch_count_d = branch_count_q + 16'd1;
        end
        if (mispredict && (mispredict_count_q != 16'hFFFF)) begin
            mispredict_count_d = mispredict_count_q + 16'd1;
        end
    end

    // Redirect and statistic registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            redirect_valid_q   <= redirect_valid_d;
            redirect_pc_q      <= redirect_pc_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign bus.redirect_valid   = redirect_valid_q;
    assign bus.redirect_pc      = redirect_pc_q;
    assign bus.branch_count     = branch_count_q;
    assign bus.mispredict_count = mispredict_count_q;

endmodule
